// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage store path and data memory.
// Stores retire into a DEPTH-entry FIFO and drain to memory over valid/ready.
// Loads search the buffer combinationally: the youngest matching word store is
// forwarded, and a pending byte store to the same word stalls the load.
// Optional feature: define STORE_BUF_COALESCE_EN to let a word store overwrite
// the youngest entry (same word, not the head) instead of allocating a new one.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic        st_byte,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_byte,
  input  logic        drain,
  output logic        empty
);

  localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] byte_q;
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;

  logic        push, pop, coal;
  logic [31:0] st_wdata;

  // Word-offset bits of the load address never take part in the match.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

`ifdef STORE_BUF_COALESCE_EN
  logic [PTR_W-1:0] yidx;

  // Coalesce candidate: youngest entry is a same-word word store and not the head.
  always_comb begin
    yidx = tail_q - PTR_W'(1);
    coal = st_valid & ~st_byte & ~drain & (count_q >= (PTR_W + 1)'(2)) & vld_q[yidx] &
           ~byte_q[yidx] & (addr_q[yidx][31:2] == st_addr[31:2]);
  end
`else
  // Coalescing disabled: every accepted store allocates.
  always_comb begin
    coal = 1'b0;
  end
`endif

  // Handshake, head presentation and occupancy flags.
  always_comb begin
    st_ready     = ((count_q != DepthCnt) | coal) & ~drain;
    push         = st_valid & st_ready & ~coal;
    mem_wr_valid = (count_q != '0);
    pop          = mem_wr_valid & mem_wr_ready;
    mem_wr_addr  = addr_q[head_q];
    mem_wr_data  = data_q[head_q];
    mem_wr_byte  = byte_q[head_q];
    empty        = (count_q == '0);
    // Byte stores keep only the low byte so memory sees a clean value.
    st_wdata     = st_byte ? {24'h0, st_data[7:0]} : st_data;
  end

  // Occupancy update: a simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Load lookup: scan oldest to youngest so the last match wins.
  always_comb begin
    logic             found;
    logic             fbyte;
    logic [31:0]      fdata;
    logic [PTR_W-1:0] idx;
    found    = 1'b0;
    fbyte    = 1'b0;
    fdata    = '0;
    idx      = '0;
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (((PTR_W + 1)'(i) < count_q) && vld_q[idx] &&
          (addr_q[idx][31:2] == ld_addr[31:2])) begin
        found = 1'b1;
        fbyte = byte_q[idx];
        fdata = data_q[idx];
      end
    end
    if (ld_valid && found) begin
      if (fbyte) begin
        ld_stall = 1'b1;
      end else begin
        ld_hit  = 1'b1;
        ld_data = fdata;
      end
    end
  end

  // Entry storage and pointers; popped entries are zeroed so idle outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      byte_q  <= '0;
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q]  <= 1'b0;
        byte_q[head_q] <= 1'b0;
        addr_q[head_q] <= '0;
        data_q[head_q] <= '0;
        head_q         <= head_q + 1'b1;
      end
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        byte_q[tail_q] <= st_byte;
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_wdata;
        tail_q         <= tail_q + 1'b1;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (coal) begin
        data_q[yidx] <= st_data;
      end
`endif
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (default build, coalescing disabled).
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_byte;
  logic [31:0] st_addr, st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        mem_wr_byte;
  logic        drain;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_byte      (st_byte),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_ready     (st_ready),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit),
    .ld_data      (ld_data),
    .ld_stall     (ld_stall),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_byte  (mem_wr_byte),
    .drain        (drain),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        b;
  } wr_t;

  typedef struct {
    logic        sv;
    logic        sb;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        lv;
    logic [31:0] la;
    logic        rdy;
    logic        dr;
    logic        e_hit;
    logic        e_stall;
    logic [31:0] e_data;
  } vec_t;

  wr_t  q[$];
  vec_t vecs[14];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic sb, input logic [31:0] sa,
                       input logic [31:0] sd, input logic lv, input logic [31:0] la,
                       input logic rdy, input logic dr);
    st_valid     = sv;
    st_byte      = sb;
    st_addr      = sa;
    st_data      = sd;
    ld_valid     = lv;
    ld_addr      = la;
    mem_wr_ready = rdy;
    drain        = dr;
    #1;
  endtask

  // Scoreboard: model occupancy from the queue, check handshake, pop/push entries.
  task automatic score();
    logic exp_rdy, exp_push, exp_pop;
    wr_t  e;
    exp_rdy  = (q.size() != DEPTH) && !drain;
    exp_pop  = (q.size() != 0) && mem_wr_ready;
    exp_push = st_valid && exp_rdy;
    chk1("st_ready", st_ready, exp_rdy);
    chk1("mem_wr_valid", mem_wr_valid, q.size() != 0);
    chk1("empty", empty, q.size() == 0);
    if (q.size() == 0) chk32("idle_wr_addr", mem_wr_addr, 32'h0);
    if (exp_pop) begin
      e = q.pop_front();
      chk32("wr_addr", mem_wr_addr, e.a);
      chk32("wr_data", mem_wr_data, e.d);
      chk1("wr_byte", mem_wr_byte, e.b);
    end
    if (exp_push) begin
      e.a = st_addr;
      e.d = st_byte ? {24'h0, st_data[7:0]} : st_data;
      e.b = st_byte;
      q.push_back(e);
    end
  endtask

  task automatic step(input logic sv, input logic sb, input logic [31:0] sa,
                      input logic [31:0] sd, input logic lv, input logic [31:0] la,
                      input logic rdy, input logic dr);
    drive(sv, sb, sa, sd, lv, la, rdy, dr);
    score();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          sv    sb    st_addr st_data       lv    ld_addr rdy   dr    hit   stall data
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h12, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h20, 32'h11111111, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h20, 32'h22222222, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222};
    vecs[8]  = '{1'b1, 1'b1, 32'h21, 32'h000000AB, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h23, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h00, 32'h0,        1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    #1;
    chk1("rst_st_ready", st_ready, 1'b1);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_wr_valid", mem_wr_valid, 1'b0);
    chk1("rst_ld_hit", ld_hit, 1'b0);
    chk1("rst_ld_stall", ld_stall, 1'b0);
    chk32("rst_wr_data", mem_wr_data, 32'h0);
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: single store/drain, youngest-word forwarding, byte-store stall.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].sv, vecs[i].sb, vecs[i].sa, vecs[i].sd, vecs[i].lv, vecs[i].la,
            vecs[i].rdy, vecs[i].dr);
      score();
      chk1($sformatf("vec%0d_ld_hit", i), ld_hit, vecs[i].e_hit);
      chk1($sformatf("vec%0d_ld_stall", i), ld_stall, vecs[i].e_stall);
      if (vecs[i].e_hit || !vecs[i].lv)
        chk32($sformatf("vec%0d_ld_data", i), ld_data, vecs[i].e_data);
      @(posedge clk);
      #1;
    end

    // Fill to full; the fifth store must be dropped, then drain in order.
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'b0, 32'(4 * k), 32'hA0 + 32'(k), 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Refill across the pointer wrap, then steady push+pop at count 2.
    step(1'b1, 1'b0, 32'h40, 32'h4040, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h44, 32'h4444, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      step(1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'hC000 + 32'(k), 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Drain with three pending and ready toggling; stores attempted are refused.
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'hD0 + 32'(k), 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++)
      step(1'b1, 1'b0, 32'h300, 32'hBAD, 1'b0, 32'h0, logic'(k % 2), 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset with stores pending.
    step(1'b1, 1'b0, 32'h400, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h404, 32'h2, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0);
    chk1("pre_rst_hit", ld_hit, 1'b1);
    chk1("pre_rst_wr_valid", mem_wr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async_rst_empty", empty, 1'b1);
    chk1("async_rst_wr_valid", mem_wr_valid, 1'b0);
    chk1("async_rst_ld_hit", ld_hit, 1'b0);
    q.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
